// File: rtl/fp_pkg.sv
// Shared definitions for the FP result stage.
// Contents: binary32 field widths, the canonical quiet NaN, the bit index of
// each fclass category, the bit index of each sticky exception flag, and the
// record type held in each skid-buffer entry.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int CLASS_W = 10;
    localparam int FLAG_W  = 5;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    // fclass one-hot bit positions
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

    // fflags bit positions, packed as {NV,DZ,OF,UF,NX}
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // One buffered result together with its classification
    typedef struct packed {
        logic [31:0]        result;
        logic [CLASS_W-1:0] cls;
    } fp_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 classifier.
// Ports:
//   value  in   32  binary32 value {sign,exp,frac}
//   cls    out  10  one-hot fclass vector (bit positions from fp_pkg)
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]        value,
    output logic [CLASS_W-1:0] cls
);

    logic              sign_s;
    logic [EXP_W-1:0]  exp_s;
    logic [FRAC_W-1:0] frac_s;

    assign sign_s = value[31];
    assign exp_s  = value[30 -: EXP_W];
    assign frac_s = value[FRAC_W-1:0];

    // Decode exponent/fraction into exactly one class bit
    always_comb begin
        cls = {CLASS_W{1'b0}};
        if (exp_s == 8'hFF) begin
            if (frac_s == 23'h0) begin
                if (sign_s) begin
                    cls[CLS_NEG_INF] = 1'b1;
                end else begin
                    cls[CLS_POS_INF] = 1'b1;
                end
            end else if (frac_s[FRAC_W-1]) begin
                cls[CLS_QNAN] = 1'b1;
            end else begin
                cls[CLS_SNAN] = 1'b1;
            end
        end else if (exp_s == 8'h00) begin
            if (frac_s == 23'h0) begin
                if (sign_s) begin
                    cls[CLS_NEG_ZERO] = 1'b1;
                end else begin
                    cls[CLS_POS_ZERO] = 1'b1;
                end
            end else if (sign_s) begin
                cls[CLS_NEG_SUB] = 1'b1;
            end else begin
                cls[CLS_POS_SUB] = 1'b1;
            end
        end else if (sign_s) begin
            cls[CLS_NEG_NORM] = 1'b1;
        end else begin
            cls[CLS_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_result_stage.sv
// Registered result stage behind the FP adder.
// Canonicalises NaNs, saturates overflow to signed infinity, optionally
// flushes underflow to signed zero, classifies the value, accumulates sticky
// exception flags and buffers results in a 2-entry skid buffer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready is registered)
//   in_result                raw adder result
//   in_overflow/underflow/inexact  adder status
//   out_valid/out_ready      downstream handshake
//   out_result, out_class    processed value and its one-hot fclass
//   fflags                   sticky {NV,DZ,OF,UF,NX}
//   flags_clear              clear sticky flags
//   result_count             delivered-result counter, wraps
module fp_result_stage
    import fp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit FTZ   = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_result,
    input  logic               in_overflow,
    input  logic               in_underflow,
    input  logic               in_inexact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [CLASS_W-1:0] out_class,
    output logic [FLAG_W-1:0]  fflags,
    input  logic               flags_clear,
    output logic [CNT_W-1:0]   result_count
);

    logic              sign_s;
    logic [EXP_W-1:0]  exp_s;
    logic [FRAC_W-1:0] frac_s;
    logic              is_nan_s;
    logic [XLEN-1:0]   proc_result_s;
    logic [XLEN-1:0]   class_src_s;
    logic [CLASS_W-1:0] proc_class_s;
    logic [FLAG_W-1:0] new_flags_s;
    logic              accept_s;
    logic              deliver_s;

    fp_entry_t         out_entry_r;
    fp_entry_t         skid_entry_r;
    fp_entry_t         new_entry_s;
    logic              out_valid_r;
    logic              skid_valid_r;
    logic [FLAG_W-1:0] fflags_r;
    logic [CNT_W-1:0]  count_r;

    assign sign_s   = in_result[XLEN-1];
    assign exp_s    = in_result[XLEN-2 -: EXP_W];
    assign frac_s   = in_result[FRAC_W-1:0];
    assign is_nan_s = (exp_s == 8'hFF) && (frac_s != 23'h0);

    // Apply NaN / overflow / underflow rules in priority order and derive new flags
    always_comb begin
        proc_result_s = in_result;
        new_flags_s   = 5'b00000;
        if (is_nan_s) begin
            proc_result_s       = CANON_QNAN;
            new_flags_s[FLG_NV] = ~frac_s[FRAC_W-1];
        end else if (in_overflow) begin
            proc_result_s       = {sign_s, 8'hFF, 23'h000000};
            new_flags_s[FLG_OF] = 1'b1;
            new_flags_s[FLG_NX] = 1'b1;
        end else if (in_underflow && FTZ) begin
            proc_result_s       = {sign_s, 31'h0000_0000};
            new_flags_s[FLG_UF] = 1'b1;
            new_flags_s[FLG_NX] = 1'b1;
        end else begin
            proc_result_s       = in_result;
            new_flags_s[FLG_NX] = in_inexact;
        end
    end

    // The canonical NaN is always quiet, so NaNs are classified on the raw
    // input to keep the signalling/quiet distinction visible downstream.
    assign class_src_s = is_nan_s ? in_result : proc_result_s;

    fp_classify u_classify (
        .value (class_src_s),
        .cls   (proc_class_s)
    );

    assign new_entry_s = '{result: proc_result_s, cls: proc_class_s};

    // Skid full means no room; in_ready depends only on registered state
    assign in_ready  = ~skid_valid_r;
    assign accept_s  = in_valid && ~skid_valid_r;
    assign deliver_s = out_valid_r && out_ready;

    // Two-entry FIFO: primary output register backed by one skid register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            out_entry_r  <= '{result: 32'h0000_0000, cls: 10'b0};
            skid_entry_r <= '{result: 32'h0000_0000, cls: 10'b0};
        end else if (deliver_s) begin
            if (skid_valid_r) begin
                // skid full implies no accept this cycle
                out_entry_r  <= skid_entry_r;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_entry_r  <= new_entry_s;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else if (accept_s) begin
            if (out_valid_r) begin
                skid_entry_r <= new_entry_s;
                skid_valid_r <= 1'b1;
            end else begin
                out_entry_r  <= new_entry_s;
                out_valid_r  <= 1'b1;
            end
        end
    end

    // Sticky exception flags; a clear coinciding with an accept keeps only the new flags
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_r <= 5'b00000;
        end else if (flags_clear) begin
            fflags_r <= accept_s ? new_flags_s : 5'b00000;
        end else if (accept_s) begin
            fflags_r <= fflags_r | new_flags_s;
        end
    end

    // Count delivered results, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (deliver_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid    = out_valid_r;
    assign out_result   = out_entry_r.result;
    assign out_class    = out_entry_r.cls;
    assign fflags       = fflags_r;
    assign result_count = count_r;

endmodule

// File: tb/tb_fp_result_stage.sv
module tb_fp_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic        in_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [9:0]  out_class;
    logic [4:0]  fflags;
    logic        flags_clear;
    logic [15:0] result_count;

    always #5 clk = ~clk;

    fp_result_stage #(.XLEN(32), .FTZ(1'b1), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .in_inexact   (in_inexact),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_class    (out_class),
        .fflags       (fflags),
        .flags_clear  (flags_clear),
        .result_count (result_count)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] in;
        logic        o;
        logic        u;
        logic        x;
        logic [31:0] res;
        int          cls;
        logic [4:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [9:0]  cls;
    } exp_t;

    vec_t tbl[13];
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic o, input logic u, input logic x);
        in_valid     = v;
        in_result    = r;
        in_overflow  = o;
        in_underflow = u;
        in_inexact   = x;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Class index from magnitude ordering of the bit pattern
    function automatic int ref_class(input logic [31:0] v);
        logic [31:0] a;
        int mag;
        a = v & 32'h7FFF_FFFF;
        if (a > 32'h7F80_0000) return (a >= 32'h7FC0_0000) ? 9 : 8;
        if (a == 32'h7F80_0000)      mag = 3;
        else if (a >= 32'h0080_0000) mag = 2;
        else if (a != 32'h0)         mag = 1;
        else                         mag = 0;
        return v[31] ? (3 - mag) : (4 + mag);
    endfunction

    task automatic ref_process(input logic [31:0] v, input logic o, input logic u, input logic x,
                               output logic [31:0] res, output logic [9:0] cls, output logic [4:0] flg);
        logic [31:0] a;
        a = v & 32'h7FFF_FFFF;
        if (a > 32'h7F80_0000) begin
            res = 32'h7FC0_0000;
            flg = (a < 32'h7FC0_0000) ? 5'b10000 : 5'b00000;
            cls = 10'd1 << ref_class(v);
        end else begin
            if (o) begin
                res = (v & 32'h8000_0000) | 32'h7F80_0000;
                flg = 5'b00101;
            end else if (u) begin
                res = v & 32'h8000_0000;
                flg = 5'b00011;
            end else begin
                res = v;
                flg = x ? 5'b00001 : 5'b00000;
            end
            cls = 10'd1 << ref_class(res);
        end
    endtask

    function automatic logic [31:0] rand_val();
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: begin e = 8'hFF; f = 23'($urandom_range(1, 32'h7FFFFF)); end
            2: begin e = 8'hFF; f = 23'h0; end
            3: begin e = 8'h00; f = 23'h0; end
            4: begin e = 8'h00; f = 23'($urandom_range(1, 32'h7FFFFF)); end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, f};
    endfunction

    initial begin
        logic [31:0] r_res;
        logic [9:0]  r_cls;
        logic [4:0]  r_flg;
        logic [4:0]  m_flags;
        logic [15:0] m_cnt;

        tbl[0]  = '{32'hBF80_0000, 1'b0, 1'b0, 1'b0, 32'hBF80_0000, 1, 5'b00000};
        tbl[1]  = '{32'h7F80_0001, 1'b0, 1'b0, 1'b0, 32'h7FC0_0000, 8, 5'b10000};
        tbl[2]  = '{32'h7FC0_0001, 1'b0, 1'b0, 1'b0, 32'h7FC0_0000, 9, 5'b00000};
        tbl[3]  = '{32'h7F7F_FFFF, 1'b1, 1'b0, 1'b1, 32'h7F80_0000, 7, 5'b00101};
        tbl[4]  = '{32'h8000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 3, 5'b00011};
        tbl[5]  = '{32'h0040_0000, 1'b0, 1'b0, 1'b1, 32'h0040_0000, 5, 5'b00001};
        tbl[6]  = '{32'hFF80_0000, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 0, 5'b00000};
        tbl[7]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4, 5'b00000};
        tbl[8]  = '{32'h3F80_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 6, 5'b00000};
        tbl[9]  = '{32'h807F_FFFF, 1'b0, 1'b0, 1'b0, 32'h807F_FFFF, 2, 5'b00000};
        tbl[10] = '{32'hFFC0_0000, 1'b0, 1'b0, 1'b0, 32'h7FC0_0000, 9, 5'b00000};
        tbl[11] = '{32'h7F80_0010, 1'b1, 1'b0, 1'b1, 32'h7FC0_0000, 8, 5'b10000};
        tbl[12] = '{32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h7F80_0000, 7, 5'b00101};

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        out_ready   = 1'b1;
        flags_clear = 1'b0;
        do_reset();

        // reset state
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_class", 32'(out_class), 32'h0);
        check("rst_fflags", 32'(fflags), 32'h0);
        check("rst_count", 32'(result_count), 32'h0);

        // table: each vector accepted with a clear so fflags equals its own flags
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, tbl[i].in, tbl[i].o, tbl[i].u, tbl[i].x);
            flags_clear = 1'b1;
            tick();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            flags_clear = 1'b0;
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'h1);
            check($sformatf("tbl%0d_result", i), out_result, tbl[i].res);
            check($sformatf("tbl%0d_class", i), 32'(out_class), 32'(10'd1 << tbl[i].cls));
            check($sformatf("tbl%0d_fflags", i), 32'(fflags), 32'(tbl[i].flg));
            tick();
        end

        // sNaN then qNaN: NV sticks, qNaN adds nothing
        flags_clear = 1'b1; tick(); flags_clear = 1'b0;
        drive(1'b1, 32'h7F80_0001, 1'b0, 1'b0, 1'b0); tick();
        check("snan_class", 32'(out_class), 32'h100);
        check("snan_fflags", 32'(fflags), 32'h10);
        drive(1'b1, 32'h7FC0_0001, 1'b0, 1'b0, 1'b0); tick();
        check("qnan_class", 32'(out_class), 32'h200);
        check("qnan_fflags", 32'(fflags), 32'h10);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();

        // overflow then underflow accumulate
        flags_clear = 1'b1; tick(); flags_clear = 1'b0;
        drive(1'b1, 32'h7F7F_FFFF, 1'b1, 1'b0, 1'b0); tick();
        check("ovf_fflags", 32'(fflags), 32'h05);
        drive(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0); tick();
        check("unf_result", out_result, 32'h8000_0000);
        check("unf_fflags", 32'(fflags), 32'h07);
        // clear together with an inexact accept
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); flags_clear = 1'b1; tick(); flags_clear = 1'b0;
        drive(1'b1, 32'h7F7F_FFFF, 1'b1, 1'b0, 1'b0); tick();
        check("pre_clr_fflags", 32'(fflags), 32'h05);
        drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b1); flags_clear = 1'b1; tick();
        flags_clear = 1'b0;
        check("clr_accept_fflags", 32'(fflags), 32'h01);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();

        // backpressure: 1 and 2 absorbed, 3 held off, then drained in order
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0); tick();
        check("bp_ready1", 32'(in_ready), 32'h1);
        drive(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0); tick();
        check("bp_ready2", 32'(in_ready), 32'h0);
        drive(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0); tick();
        check("bp_hold_out", out_result, 32'h3F80_0000);
        check("bp_hold_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1; tick();
        check("bp_out2", out_result, 32'h4000_0000);
        check("bp_ready3", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("bp_out3", out_result, 32'h4040_0000);
        tick();
        check("bp_empty", 32'(out_valid), 32'h0);
        check("bp_count", 32'(result_count), 32'h3);

        // reset with both entries full
        out_ready = 1'b0;
        drive(1'b1, 32'h7F7F_FFFF, 1'b1, 1'b0, 1'b0); tick(); tick();
        check("full_ready", 32'(in_ready), 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("full_rst_valid", 32'(out_valid), 32'h0);
        check("full_rst_ready", 32'(in_ready), 32'h1);
        check("full_rst_fflags", 32'(fflags), 32'h0);
        check("full_rst_count", 32'(result_count), 32'h0);

        // counter wrap
        out_ready = 1'b1;
        drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
        check("count_ffff", 32'(result_count), 32'hFFFF);
        drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
        check("count_wrap", 32'(result_count), 32'h0);

        // randomized traffic against the queue model
        do_reset();
        q.delete();
        m_flags = 5'b00000;
        m_cnt   = 16'h0000;
        for (int c = 0; c < 2000; c++) begin
            logic v, ordy, clr, o, u, x, acc, dlv;
            logic [31:0] r;
            check("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
            check("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                check("rnd_result", out_result, q[0].res);
                check("rnd_class", 32'(out_class), 32'(q[0].cls));
            end
            check("rnd_fflags", 32'(fflags), 32'(m_flags));
            check("rnd_count", 32'(result_count), 32'(m_cnt));
            v    = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 70);
            clr  = ($urandom_range(0, 99) < 5);
            o    = ($urandom_range(0, 99) < 8);
            u    = ($urandom_range(0, 99) < 10);
            x    = ($urandom_range(0, 99) < 40);
            r    = rand_val();
            drive(v, r, o, u, x);
            out_ready   = ordy;
            flags_clear = clr;
            ref_process(r, o, u, x, r_res, r_cls, r_flg);
            acc = v && (q.size() < 2);
            dlv = (q.size() > 0) && ordy;
            tick();
            if (dlv) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (clr)      m_flags = acc ? r_flg : 5'b00000;
            else if (acc) m_flags = m_flags | r_flg;
            if (acc) q.push_back('{res: r_res, cls: r_cls});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
